// File: rtl/seg_display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display driver.
// Glyphs are active-high {g,f,e,d,c,b,a}.
package seg_display_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h00;

  localparam seg7_t GLYPHS [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  // Bits needed to hold a count of 0..n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Bundle of data-load, display-control and display-pin signals for seg_scan_driver.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  import seg_display_pkg::*;

  // Load handshake: a one-cycle load strobe captures bcd_in/dp_in into the
  // pending buffer (latest strobe wins). There is no ready; load_ack pulses
  // for one cycle when that pending data is promoted to the display at a
  // frame boundary.
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    load_ack;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    lz_blank;
  seg7_t                   seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;

  modport master (
    output bcd_in, dp_in, load, blink_mask, lz_blank,
    input  load_ack, seg, dp, an
  );

  modport slave (
    input  bcd_in, dp_in, load, blink_mask, lz_blank,
    output load_ack, seg, dp, an
  );

endinterface

// File: rtl/seg_scan_driver_bcd_to_seg7.sv
// Combinational BCD to active-high 7-segment glyph; codes 10-15 show blank.
module bcd_to_seg7
  import seg_display_pkg::*;
(
  input  logic [3:0] bcd,
  output seg7_t      glyph
);

  always_comb begin
    glyph = SEG_BLANK;
    if (bcd <= 4'd9) glyph = GLYPHS[bcd];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode 7-segment driver with double-buffered loading,
// blank gap between digits, blink, decimal points and leading-zero suppression.
module seg_scan_driver
  import seg_display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 4000,
  parameter int BLINK_HZ     = 1,
  parameter int BLANK_CYCLES = 4,
  parameter int ACTIVE_LOW   = 1
) (
  input logic       clk,
  input logic       rst_n,
  seg_scan_if.slave bus
);

  localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int IDX_W     = cnt_width(NUM_DIGITS);
  localparam int SCAN_W    = cnt_width(SCAN_DIV);
  localparam int BLINK_W   = cnt_width(BLINK_DIV);
  localparam int BLANK_W   = cnt_width(BLANK_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [SCAN_W-1:0]       scan_cnt;
  logic [BLINK_W-1:0]      blink_cnt;
  logic                    blink_phase;
  logic [IDX_W-1:0]        idx;
  logic [BLANK_W-1:0]      blank_cnt;
  logic [4*NUM_DIGITS-1:0] act_bcd, pend_bcd;
  logic [NUM_DIGITS-1:0]   act_dp, pend_dp;
  logic                    pend_valid;
  logic                    load_ack_q;
  logic [NUM_DIGITS-1:0]   an_q;
  seg7_t                   seg_q;
  logic                    dp_q;

  logic                    tick, frame_end;
  logic [3:0]              cur_bcd;
  logic                    cur_dp, lz_sup, blink_off, dp_n;
  logic [NUM_DIGITS-1:0]   an_n, zero_from;
  seg7_t                   glyph, seg_n;

  assign tick      = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign frame_end = tick && (idx == LAST_IDX);

  // zero_from[i]: digit i and every digit above it hold zero.
  always_comb begin
    zero_from = '0;
    zero_from[NUM_DIGITS-1] = (act_bcd[4*NUM_DIGITS-1 -: 4] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--)
      zero_from[i] = zero_from[i+1] && (act_bcd[4*i +: 4] == 4'd0);
  end

  always_comb begin
    cur_bcd   = '0;
    cur_dp    = 1'b0;
    lz_sup    = 1'b0;
    blink_off = 1'b0;
    an_n      = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_bcd   = act_bcd[4*i +: 4];
        cur_dp    = act_dp[i];
        lz_sup    = bus.lz_blank && (i != 0) && zero_from[i];
        blink_off = blink_phase && bus.blink_mask[i];
        an_n[i]   = (blank_cnt == '0);
      end
    end
  end

  bcd_to_seg7 u_dec (
    .bcd   (cur_bcd),
    .glyph (glyph)
  );

  // Blink overrides everything; a zero-suppressed digit still shows its dp.
  always_comb begin
    seg_n = (blink_off || lz_sup) ? SEG_BLANK : glyph;
    dp_n  = blink_off ? 1'b0 : cur_dp;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      idx         <= '0;
      blank_cnt   <= '0;
      act_bcd     <= '0;
      act_dp      <= '0;
      pend_bcd    <= '0;
      pend_dp     <= '0;
      pend_valid  <= 1'b0;
      load_ack_q  <= 1'b0;
      an_q        <= {NUM_DIGITS{POL}};
      seg_q       <= {7{POL}};
      dp_q        <= POL;
    end else begin
      scan_cnt <= tick ? '0 : scan_cnt + 1'b1;

      if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      if (tick) begin
        idx       <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        blank_cnt <= BLANK_W'(BLANK_CYCLES);
      end else if (blank_cnt != '0) begin
        blank_cnt <= blank_cnt - 1'b1;
      end

      // A load landing on the boundary cycle replaces any pending data and
      // waits for the next boundary instead of being promoted now.
      load_ack_q <= 1'b0;
      if (bus.load) begin
        pend_bcd   <= bus.bcd_in;
        pend_dp    <= bus.dp_in;
        pend_valid <= 1'b1;
      end else if (frame_end && pend_valid) begin
        act_bcd    <= pend_bcd;
        act_dp     <= pend_dp;
        pend_valid <= 1'b0;
        load_ack_q <= 1'b1;
      end

      an_q  <= an_n ^ {NUM_DIGITS{POL}};
      seg_q <= seg_n ^ {7{POL}};
      dp_q  <= dp_n ^ POL;
    end
  end

  assign bus.load_ack = load_ack_q;
  assign bus.an       = an_q;
  assign bus.seg      = seg_q;
  assign bus.dp       = dp_q;

endmodule
